// File: rtl/fabric_pkg.sv
// Shared types and constants for the fabric port scheduler and its arbiter.
package fabric_pkg;

  typedef logic [5:0]  port_t;
  typedef logic [11:0] vlan_t;
  typedef logic [47:0] macaddr_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WAIT_TX,
    FORWARD,
    DROP
  } sched_state_t;

  localparam int unsigned MAC_GROUP_BIT = 40;

endpackage

// File: rtl/fabric_rr_arbiter.sv
// Combinational round-robin arbiter: first set request after ptr, wrapping modulo N.
module fabric_rr_arbiter #(
  parameter int N  = 28,
  parameter int PB = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PB-1:0] ptr,
  output logic          gnt_valid,
  output logic [PB-1:0] gnt_idx
);

  always_comb begin
    int unsigned idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    // ptr < N and i <= N, so a single subtraction replaces the modulo
    for (int unsigned i = 1; i <= N; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = PB'(idx);
      end
    end
  end

endmodule

// File: rtl/fabric_port_scheduler.sv
// Round-robin frame scheduler: one MAC lookup per frame, unicast/flood/drop
// mask, TX-space wait, then streams the frame from the chosen RX FIFO.
module fabric_port_scheduler
  import fabric_pkg::*;
#(
  parameter int NUM_PORTS      = 28,
  parameter int DATA_WIDTH     = 32,
  parameter int LOOKUP_LATENCY = 2,
  parameter int PORT_BITS      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            rx_fwd_en,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] rx_data,
  input  logic [NUM_PORTS-1:0]            rx_last,
  input  logic [NUM_PORTS*12-1:0]         rx_vlan,
  input  logic [NUM_PORTS*48-1:0]         rx_src_mac,
  input  logic [NUM_PORTS*48-1:0]         rx_dst_mac,
  output logic [NUM_PORTS-1:0]            rx_pop,
  output logic                            mac_lookup_en,
  output logic [11:0]                     mac_lookup_src_vlan,
  output logic [47:0]                     mac_lookup_src_mac,
  output logic [PORT_BITS-1:0]            mac_lookup_src_port,
  output logic [47:0]                     mac_lookup_dst_mac,
  input  logic                            mac_lookup_hit,
  input  logic [PORT_BITS-1:0]            mac_lookup_dst_port,
  input  logic [NUM_PORTS-1:0]            tx_ready,
  output logic [NUM_PORTS-1:0]            tx_en,
  output logic [DATA_WIDTH-1:0]           tx_data,
  output logic                            tx_last,
  output logic                            busy,
  output logic [31:0]                     cnt_unicast,
  output logic [31:0]                     cnt_flood,
  output logic [31:0]                     cnt_drop
);

  localparam int LK_W = $clog2(LOOKUP_LATENCY + 1);
  localparam logic [NUM_PORTS-1:0] ONE_HOT0  = NUM_PORTS'(1);
  localparam logic [NUM_PORTS-1:0] ALL_PORTS = '1;

  sched_state_t           state;
  logic [PORT_BITS-1:0]   src;
  logic [PORT_BITS-1:0]   rr_ptr;
  logic [NUM_PORTS-1:0]   mask;
  logic                   is_flood;
  logic [LK_W-1:0]        lk_cnt;

  logic                   gnt_valid;
  logic [PORT_BITS-1:0]   gnt_idx;

  logic [DATA_WIDTH-1:0]  rx_word  [NUM_PORTS];
  vlan_t                  vlan_w   [NUM_PORTS];
  macaddr_t               smac_w   [NUM_PORTS];
  macaddr_t               dmac_w   [NUM_PORTS];

  logic                   lk_flood;
  logic [NUM_PORTS-1:0]   lk_mask;

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      rx_word[p] = rx_data[p*DATA_WIDTH +: DATA_WIDTH];
      vlan_w[p]  = rx_vlan[p*12 +: 12];
      smac_w[p]  = rx_src_mac[p*48 +: 48];
      dmac_w[p]  = rx_dst_mac[p*48 +: 48];
    end
  end

  fabric_rr_arbiter #(
    .N  (NUM_PORTS),
    .PB (PORT_BITS)
  ) u_arb (
    .req       (rx_fwd_en),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Group address or miss floods; a hit back to src or out of range empties the mask
  always_comb begin
    lk_flood = mac_lookup_dst_mac[MAC_GROUP_BIT] || !mac_lookup_hit;
    lk_mask  = '0;
    if (lk_flood)
      lk_mask = ALL_PORTS & ~(ONE_HOT0 << src);
    else if ((32'(mac_lookup_dst_port) < 32'(NUM_PORTS)) && (mac_lookup_dst_port != src))
      lk_mask = ONE_HOT0 << mac_lookup_dst_port;
  end

  always_comb begin
    rx_pop = '0;
    if (state == FORWARD || state == DROP) rx_pop[src] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      src                 <= '0;
      rr_ptr              <= PORT_BITS'(NUM_PORTS - 1);
      mask                <= '0;
      is_flood            <= 1'b0;
      lk_cnt              <= '0;
      mac_lookup_en       <= 1'b0;
      mac_lookup_src_vlan <= '0;
      mac_lookup_src_mac  <= '0;
      mac_lookup_src_port <= '0;
      mac_lookup_dst_mac  <= '0;
      tx_en               <= '0;
      tx_data             <= '0;
      tx_last             <= 1'b0;
      cnt_unicast         <= '0;
      cnt_flood           <= '0;
      cnt_drop            <= '0;
    end else begin
      mac_lookup_en <= 1'b0;
      tx_en         <= '0;
      tx_last       <= 1'b0;
      case (state)
        IDLE: if (gnt_valid) begin
          src                 <= gnt_idx;
          rr_ptr              <= gnt_idx;
          mac_lookup_en       <= 1'b1;
          mac_lookup_src_port <= gnt_idx;
          mac_lookup_src_vlan <= vlan_w[gnt_idx];
          mac_lookup_src_mac  <= smac_w[gnt_idx];
          mac_lookup_dst_mac  <= dmac_w[gnt_idx];
          lk_cnt              <= '0;
          state               <= LOOKUP;
        end
        LOOKUP: begin
          if (lk_cnt == LK_W'(LOOKUP_LATENCY)) begin
            mask     <= lk_mask;
            is_flood <= lk_flood;
            state    <= (lk_mask == '0) ? DROP : WAIT_TX;
          end else begin
            lk_cnt <= lk_cnt + 1'b1;
          end
        end
        WAIT_TX: if ((tx_ready & mask) == mask) state <= FORWARD;
        FORWARD: begin
          tx_en   <= mask;
          tx_data <= rx_word[src];
          tx_last <= rx_last[src];
          if (rx_last[src]) begin
            state <= IDLE;
            if (is_flood) cnt_flood   <= cnt_flood + 1'b1;
            else          cnt_unicast <= cnt_unicast + 1'b1;
          end
        end
        DROP: if (rx_last[src]) begin
          state    <= IDLE;
          cnt_drop <= cnt_drop + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fabric_port_scheduler.sv
// Self-checking bench: frame vector table plus hand-written wait/reset/arbitration sequences.
module tb_fabric_port_scheduler;

  localparam int NP  = 28;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int PB  = 5;
  localparam logic [NP-1:0] ONE = NP'(1);
  localparam logic [NP-1:0] ALL = '1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     rx_fwd_en;
  logic [NP*DW-1:0]  rx_data;
  logic [NP-1:0]     rx_last;
  logic [NP*12-1:0]  rx_vlan;
  logic [NP*48-1:0]  rx_src_mac;
  logic [NP*48-1:0]  rx_dst_mac;
  logic [NP-1:0]     rx_pop;
  logic              mac_lookup_en;
  logic [11:0]       mac_lookup_src_vlan;
  logic [47:0]       mac_lookup_src_mac;
  logic [PB-1:0]     mac_lookup_src_port;
  logic [47:0]       mac_lookup_dst_mac;
  logic              mac_lookup_hit;
  logic [PB-1:0]     mac_lookup_dst_port;
  logic [NP-1:0]     tx_ready;
  logic [NP-1:0]     tx_en;
  logic [DW-1:0]     tx_data;
  logic              tx_last;
  logic              busy;
  logic [31:0]       cnt_unicast, cnt_flood, cnt_drop;

  always #5 clk = ~clk;

  fabric_port_scheduler #(
    .NUM_PORTS      (NP),
    .DATA_WIDTH     (DW),
    .LOOKUP_LATENCY (LAT)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rx_fwd_en           (rx_fwd_en),
    .rx_data             (rx_data),
    .rx_last             (rx_last),
    .rx_vlan             (rx_vlan),
    .rx_src_mac          (rx_src_mac),
    .rx_dst_mac          (rx_dst_mac),
    .rx_pop              (rx_pop),
    .mac_lookup_en       (mac_lookup_en),
    .mac_lookup_src_vlan (mac_lookup_src_vlan),
    .mac_lookup_src_mac  (mac_lookup_src_mac),
    .mac_lookup_src_port (mac_lookup_src_port),
    .mac_lookup_dst_mac  (mac_lookup_dst_mac),
    .mac_lookup_hit      (mac_lookup_hit),
    .mac_lookup_dst_port (mac_lookup_dst_port),
    .tx_ready            (tx_ready),
    .tx_en               (tx_en),
    .tx_data             (tx_data),
    .tx_last             (tx_last),
    .busy                (busy),
    .cnt_unicast         (cnt_unicast),
    .cnt_flood           (cnt_flood),
    .cnt_drop            (cnt_drop)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RX FIFO model: per-port frame length, frames pending, head index
  int flen [NP];
  int nfr  [NP];
  int widx [NP];
  int fno  [NP];
  int pops [NP];
  logic [47:0] smac_a [NP];
  logic [47:0] dmac_a [NP];
  logic [11:0] vlan_a [NP];

  function automatic logic [31:0] word_of(input int p, input int f, input int i);
    return {8'hA5, 8'(p), 8'(f), 8'(i)};
  endfunction

  task automatic drive_rx();
    for (int p = 0; p < NP; p++) begin
      rx_fwd_en[p]            = (nfr[p] > 0);
      rx_data[p*DW +: DW]     = word_of(p, fno[p], widx[p]);
      rx_last[p]              = (widx[p] == flen[p] - 1);
      rx_vlan[p*12 +: 12]     = vlan_a[p];
      rx_src_mac[p*48 +: 48]  = smac_a[p];
      rx_dst_mac[p*48 +: 48]  = dmac_a[p];
    end
  endtask

  task automatic load_port(input int p, input int n, input int frames, input logic [47:0] dm);
    flen[p]   = n;
    nfr[p]    = frames;
    widx[p]   = 0;
    dmac_a[p] = dm;
    drive_rx();
  endtask

  // Scoreboard of expected TX words and expected lookup source ports
  typedef struct {
    logic [NP-1:0] mask;
    logic [31:0]   data;
    logic          last;
  } txe_t;
  txe_t sbq [$];
  int   lkq [$];

  task automatic expect_frame(input int p, input int n, input logic [NP-1:0] m, input int fofs);
    txe_t e;
    lkq.push_back(p);
    if (m != '0)
      for (int i = 0; i < n; i++) begin
        e.mask = m;
        e.data = word_of(p, fno[p] + fofs, i);
        e.last = (i == n - 1);
        sbq.push_back(e);
      end
  endtask

  logic [NP-1:0] pop_s, fwd_s;
  initial begin
    forever begin
      @(negedge clk);
      pop_s = rx_pop;
      fwd_s = rx_fwd_en;
      if (pop_s != '0) check("pop_onehot", 64'($onehot(pop_s)), 64'd1);
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++)
        if (pop_s[p]) begin
          check($sformatf("pop_has_frame_p%0d", p), 64'(fwd_s[p]), 64'd1);
          pops[p]++;
          if (widx[p] >= flen[p] - 1) begin
            widx[p] = 0;
            fno[p]++;
            if (nfr[p] > 0) nfr[p]--;
          end else begin
            widx[p]++;
          end
        end
      drive_rx();
    end
  end

  // MAC table model: result valid only LAT cycles after the strobe, wrong otherwise
  logic          tb_hit;
  logic [PB-1:0] tb_dst;
  int            age = 1000;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mac_lookup_en) begin
        age = 0;
        if (lkq.size() == 0) check("lookup_unexpected", 64'd1, 64'd0);
        else begin
          int p;
          p = lkq.pop_front();
          check("lk_src_port", 64'(mac_lookup_src_port), 64'(p));
          check("lk_src_mac",  64'(mac_lookup_src_mac),  64'(smac_a[p]));
          check("lk_dst_mac",  64'(mac_lookup_dst_mac),  64'(dmac_a[p]));
          check("lk_vlan",     64'(mac_lookup_src_vlan), 64'(vlan_a[p]));
        end
      end else if (age < 1000) age++;
      mac_lookup_hit      = (age == LAT) ? tb_hit : ~tb_hit;
      mac_lookup_dst_port = (age == LAT) ? tb_dst : (tb_dst ^ PB'(1));
    end
  end

  int cyc = 0;
  int tx_cnt = 0;
  int tx_first = -1;
  int tx_lastc = -1;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (tx_en != '0) begin
        tx_cnt++;
        if (tx_first < 0) tx_first = cyc;
        tx_lastc = cyc;
        if (sbq.size() == 0) check("tx_unexpected", 64'(tx_en), 64'd0);
        else begin
          txe_t e;
          e = sbq.pop_front();
          check("tx_mask", 64'(tx_en),   64'(e.mask));
          check("tx_data", 64'(tx_data), 64'(e.data));
          check("tx_last", 64'(tx_last), 64'(e.last));
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rx_fwd_en == '0 && !busy && sbq.size() == 0 && lkq.size() == 0) && n < 400);
    check({name, "_complete"}, 64'(n < 400), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rx_pop"}, 64'(rx_pop), 64'd0);
    check({name, "_outs"}, 64'((|tx_en) | busy | mac_lookup_en | tx_last | (|tx_data) |
          (|cnt_unicast) | (|cnt_flood) | (|cnt_drop) | (|mac_lookup_src_mac) |
          (|mac_lookup_dst_mac) | (|mac_lookup_src_vlan) | (|mac_lookup_src_port)), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sbq.delete();
    lkq.delete();
    for (int p = 0; p < NP; p++) begin
      nfr[p]  = 0;
      widx[p] = 0;
    end
    drive_rx();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
  endtask

  typedef struct {
    int            src;
    int            n;
    logic [47:0]   dmac;
    logic          hit;
    int            dst;
    int            kind;   // 0 unicast, 1 flood, 2 drop
    logic [NP-1:0] mask;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int pu, pf, pd, pp;

    vecs[0] = '{3,  4, 48'h00_11_22_33_44_55, 1'b1, 7,  0, ONE << 7};
    vecs[1] = '{0,  3, 48'hff_ff_ff_ff_ff_ff, 1'b1, 3,  1, ALL & ~ONE};
    vecs[2] = '{5,  3, 48'h02_00_00_00_00_05, 1'b1, 5,  2, '0};
    vecs[3] = '{27, 2, 48'h02_00_00_00_00_99, 1'b0, 0,  1, ALL & ~(ONE << 27)};
    vecs[4] = '{10, 1, 48'h02_00_00_00_00_10, 1'b1, 30, 2, '0};
    vecs[5] = '{27, 5, 48'h02_00_00_00_00_00, 1'b1, 0,  0, ONE};
    vecs[6] = '{12, 3, 48'h01_00_5e_00_00_01, 1'b1, 2,  1, ALL & ~(ONE << 12)};

    for (int p = 0; p < NP; p++) begin
      flen[p]   = 1;
      nfr[p]    = 0;
      widx[p]   = 0;
      fno[p]    = 0;
      pops[p]   = 0;
      smac_a[p] = 48'h02_00_00_00_00_00 | 48'(p);
      dmac_a[p] = '0;
      vlan_a[p] = 12'(100 + p);
    end
    tx_ready = '1;
    tb_hit   = 1'b0;
    tb_dst   = '0;
    mac_lookup_hit      = 1'b0;
    mac_lookup_dst_port = '0;
    rst = 1'b0;
    drive_rx();
    #2;
    do_reset();

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      @(posedge clk);
      #2;
      tb_hit = v.hit;
      tb_dst = PB'(v.dst);
      pu = cnt_unicast;
      pf = cnt_flood;
      pd = cnt_drop;
      pp = pops[v.src];
      tx_cnt   = 0;
      tx_first = -1;
      expect_frame(v.src, v.n, v.mask, 0);
      load_port(v.src, v.n, 1, v.dmac);
      wait_idle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_pops", i),    64'(pops[v.src] - pp),  64'(v.n));
      check($sformatf("vec%0d_cnt_uni", i), 64'(cnt_unicast - pu), 64'(v.kind == 0));
      check($sformatf("vec%0d_cnt_fld", i), 64'(cnt_flood - pf),   64'(v.kind == 1));
      check($sformatf("vec%0d_cnt_drp", i), 64'(cnt_drop - pd),    64'(v.kind == 2));
      check($sformatf("vec%0d_tx_words", i), 64'(tx_cnt), (v.mask != '0) ? 64'(v.n) : 64'd0);
      if (v.mask != '0)
        check($sformatf("vec%0d_tx_span", i), 64'(tx_lastc - tx_first + 1), 64'(v.n));
    end

    // Arbitration: from reset port 27 alone goes first, then 2,9,20,2 with all three held
    do_reset();
    @(posedge clk);
    #2;
    tb_hit = 1'b1;
    tb_dst = PB'(1);
    expect_frame(27, 1, ONE << 1, 0);
    load_port(27, 1, 1, 48'h02_00_00_00_00_01);
    wait_idle("rr27");
    @(posedge clk);
    #2;
    do_reset();
    @(posedge clk);
    #2;
    expect_frame(2,  1, ALL & ~(ONE << 2),  0);
    expect_frame(9,  1, ALL & ~(ONE << 9),  0);
    expect_frame(20, 1, ALL & ~(ONE << 20), 0);
    expect_frame(2,  1, ALL & ~(ONE << 2),  1);
    dmac_a[9]  = 48'hff_ff_ff_ff_ff_ff;
    dmac_a[20] = 48'hff_ff_ff_ff_ff_ff;
    flen[9] = 1;  nfr[9] = 1;  widx[9] = 0;
    flen[20] = 1; nfr[20] = 1; widx[20] = 0;
    load_port(2, 1, 2, 48'hff_ff_ff_ff_ff_ff);
    wait_idle("rr_order");
    check("rr_cnt_flood", 64'(cnt_flood), 64'd4);

    // TX back-pressure: unicast to 4 held off until tx_ready[4] rises
    @(posedge clk);
    #2;
    tb_hit = 1'b1;
    tb_dst = PB'(4);
    tx_ready[4] = 1'b0;
    pu = cnt_unicast;
    expect_frame(8, 3, ONE << 4, 0);
    load_port(8, 3, 1, 48'h02_00_00_00_00_04);
    @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("wait_tx_nopop_c%0d", c), 64'(rx_pop), 64'd0);
      check($sformatf("wait_tx_busy_c%0d", c),  64'(busy),   64'd1);
    end
    @(posedge clk);
    #2;
    tx_ready[4] = 1'b1;
    @(negedge clk);
    check("ready_cycle_nopop", 64'(rx_pop), 64'd0);
    @(negedge clk);
    check("first_pop_after_ready", 64'(rx_pop), 64'(ONE << 8));
    wait_idle("wait_tx");
    check("wait_tx_cnt_uni", 64'(cnt_unicast - pu), 64'd1);

    // Reset during word 2 of a 6-word frame abandons it; port 0 then wins over 27
    begin
      int seen;
      int n;
      seen = 0;
      n = 0;
      @(posedge clk);
      #2;
      tb_dst = PB'(7);
      expect_frame(5, 6, ONE << 7, 0);
      load_port(5, 6, 1, 48'h02_00_00_00_00_07);
      while (seen < 2 && n < 100) begin
        @(negedge clk);
        n++;
        if (rx_pop[5]) seen++;
      end
      check("mid_frame_reached", 64'(seen), 64'd2);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("mid_frame_reset");
      nfr[5]  = 0;
      widx[5] = 0;
      sbq.delete();
      lkq.delete();
      tb_dst = PB'(3);
      expect_frame(0,  1, ONE << 3, 0);
      expect_frame(27, 1, ONE << 3, 0);
      flen[27] = 1; nfr[27] = 1; widx[27] = 0;
      dmac_a[27] = 48'h02_00_00_00_00_03;
      load_port(0, 1, 1, 48'h02_00_00_00_00_03);
      @(negedge clk);
      check("reset_held_nopop", 64'(rx_pop | tx_en), 64'd0);
      rst = 1'b0;
      wait_idle("post_reset");
      check("post_reset_cnt_uni", 64'(cnt_unicast), 64'd2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
